// File: rtl/ft_out_arbiter.sv
// Two-requester round-robin arbiter for the FT245 outgoing response path.
// A grant is held for a whole response transaction; an owner that idles too long is dropped with a timeout pulse.
module ft_out_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  output logic        r0_gnt,
  output logic        r0_ready,
  input  logic        r0_en,
  input  logic [31:0] r0_status,
  input  logic [31:0] r0_address,
  input  logic [27:0] r0_data_count,
  input  logic [31:0] r0_data,
  input  logic        r1_req,
  output logic        r1_gnt,
  output logic        r1_ready,
  input  logic        r1_en,
  input  logic [31:0] r1_status,
  input  logic [31:0] r1_address,
  input  logic [27:0] r1_data_count,
  input  logic [31:0] r1_data,
  input  logic        oh_ready,
  output logic        oh_en,
  output logic [31:0] out_status,
  output logic [31:0] out_address,
  output logic [27:0] out_data_count,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {IDLE, WAIT_EN, ISSUE, GAP, WAIT_OH} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic            first_q, first_d;
  logic            timeout_q, timeout_d;
  logic [27:0]     beats_left_q, beats_left_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [31:0]     status_q, status_d;
  logic [31:0]     address_q, address_d;
  logic [27:0]     count_q, count_d;
  logic [31:0]     data_q, data_d;

  logic            sel_req, sel_en;
  logic [31:0]     sel_status, sel_address, sel_data;
  logic [27:0]     sel_count;

  // Only the current owner's request-side signals are ever looked at.
  assign sel_req     = owner_q ? r1_req        : r0_req;
  assign sel_en      = owner_q ? r1_en         : r0_en;
  assign sel_status  = owner_q ? r1_status     : r0_status;
  assign sel_address = owner_q ? r1_address    : r0_address;
  assign sel_count   = owner_q ? r1_data_count : r0_data_count;
  assign sel_data    = owner_q ? r1_data       : r0_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    first_d      = first_q;
    timeout_d    = 1'b0;
    beats_left_d = beats_left_q;
    to_cnt_d     = to_cnt_q;
    status_d     = status_q;
    address_d    = address_q;
    count_d      = count_q;
    data_d       = data_q;

    unique case (state_q)
      IDLE: begin
        if (r0_req || r1_req) begin
          owner_d = (r0_req && r1_req) ? rr_ptr_q : r1_req;
          first_d = 1'b1;
          state_d = WAIT_OH;
        end
      end
      WAIT_OH: begin
        if (oh_ready) begin
          state_d  = WAIT_EN;
          to_cnt_d = '0;
        end
      end
      WAIT_EN: begin
        if (sel_en) begin
          state_d = ISSUE;
          first_d = 1'b0;
          data_d  = sel_data;
          if (first_q) begin
            status_d     = sel_status;
            address_d    = sel_address;
            count_d      = sel_count;
            beats_left_d = (sel_status[3:0] == 4'hD) ? sel_count : 28'd0;
          end else begin
            beats_left_d = beats_left_q - 28'd1;
          end
        end else if (first_q && !sel_req) begin
          state_d  = IDLE;
          rr_ptr_d = ~owner_q;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = IDLE;
          rr_ptr_d  = ~owner_q;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ISSUE: begin
        state_d = GAP;
      end
      GAP: begin
        // Host drops oh_ready one cycle late, so it is not sampled here.
        if (beats_left_q == 28'd0) begin
          state_d  = IDLE;
          rr_ptr_d = ~owner_q;
        end else begin
          state_d = WAIT_OH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      rr_ptr_q     <= 1'b0;
      first_q      <= 1'b0;
      timeout_q    <= 1'b0;
      beats_left_q <= '0;
      to_cnt_q     <= '0;
      status_q     <= '0;
      address_q    <= '0;
      count_q      <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      first_q      <= first_d;
      timeout_q    <= timeout_d;
      beats_left_q <= beats_left_d;
      to_cnt_q     <= to_cnt_d;
      status_q     <= status_d;
      address_q    <= address_d;
      count_q      <= count_d;
      data_q       <= data_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign r0_gnt         = busy && !owner_q;
  assign r1_gnt         = busy && owner_q;
  assign r0_ready       = (state_q == WAIT_EN) && !owner_q;
  assign r1_ready       = (state_q == WAIT_EN) && owner_q;
  assign oh_en          = (state_q == ISSUE);
  assign timeout_err    = timeout_q;
  assign out_status     = status_q;
  assign out_address    = address_q;
  assign out_data_count = count_q;
  assign out_data       = data_q;

endmodule

// File: tb/tb_ft_out_arbiter.sv
// Scoreboard bench for ft_out_arbiter: drivers queue the beats the host should see, a monitor checks each oh_en.
// Directed scenarios (ping, burst, round-robin, backpressure, timeout, async reset) then a randomized two-requester run.
module tb_ft_out_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, en;
  logic [31:0] st [2];
  logic [31:0] ad [2];
  logic [27:0] dc [2];
  logic [31:0] da [2];
  logic        oh_ready;
  wire         r0_gnt, r1_gnt, r0_ready, r1_ready, oh_en, busy, timeout_err;
  wire  [31:0] out_status, out_address, out_data;
  wire  [27:0] out_data_count;
  wire  [1:0]  gnt = {r1_gnt, r0_gnt};
  wire  [1:0]  rdy = {r1_ready, r0_ready};

  ft_out_arbiter #(.TIMEOUT(TO), .TO_W(16)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req[0]), .r0_gnt(r0_gnt), .r0_ready(r0_ready), .r0_en(en[0]),
    .r0_status(st[0]), .r0_address(ad[0]), .r0_data_count(dc[0]), .r0_data(da[0]),
    .r1_req(req[1]), .r1_gnt(r1_gnt), .r1_ready(r1_ready), .r1_en(en[1]),
    .r1_status(st[1]), .r1_address(ad[1]), .r1_data_count(dc[1]), .r1_data(da[1]),
    .oh_ready(oh_ready), .oh_en(oh_en),
    .out_status(out_status), .out_address(out_address),
    .out_data_count(out_data_count), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] st;
    logic [31:0] ad;
    logic [27:0] dc;
    logic [31:0] da;
  } beat_t;

  beat_t exp_q[$];
  int    exp_gnt_q[$];
  int    total = 0;
  int    bad = 0;
  bit    chk_gnt = 1'b0;
  bit    to_expected = 1'b0;
  bit    rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [159:0] outs();
    return {29'd0, r0_gnt, r1_gnt, r0_ready, r1_ready, oh_en, busy, timeout_err,
            out_status, out_address, out_data_count, out_data};
  endfunction

  function automatic beat_t mk(input logic [31:0] s, input logic [31:0] a,
                               input logic [27:0] c, input logic [31:0] d);
    beat_t b;
    b.st = s; b.ad = a; b.dc = c; b.da = d;
    return b;
  endfunction

  task automatic wait_rdy(input int id, output bit ok);
    int i;
    ok = 1'b0;
    i = 0;
    while (!ok && i < 4000) begin
      @(negedge clk);
      ok = rdy[id];
      i++;
    end
    if (!ok) chk($sformatf("ready_wait_r%0d", id), rdy[id], 1'b1);
  endtask

  task automatic wait_gnt(input int id);
    int i;
    i = 0;
    while (!gnt[id] && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk($sformatf("grant_wait_r%0d", id), gnt[id], 1'b1);
  endtask

  task automatic wait_oh();
    int i;
    i = 0;
    while (!oh_en && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk("oh_en_wait", oh_en, 1'b1);
  endtask

  // Returns at the negedge of the cycle in which oh_en must be high.
  task automatic send_beat(input int id, input logic [31:0] s, input logic [31:0] a,
                           input logic [27:0] c, input logic [31:0] d, input beat_t e,
                           input int dly, output bit ok);
    wait_rdy(id, ok);
    if (!ok) return;
    repeat (dly) @(negedge clk);
    en[id] = 1'b1; st[id] = s; ad[id] = a; dc[id] = c; da[id] = d;
    exp_q.push_back(e);
    @(negedge clk);
    en[id] = 1'b0;
    chk($sformatf("en_to_oh_en_r%0d", id), oh_en, 1'b1);
  endtask

  // Later beats drive junk headers: the host must keep seeing the first beat's header.
  task automatic run_txn(input int id, input logic [31:0] s, input logic [31:0] a,
                         input logic [27:0] c, input int maxd, input bit keep, input bit seq);
    int n;
    bit ok;
    logic [31:0] d;
    n = (s[3:0] == 4'hD) ? int'(c) + 1 : 1;
    req[id] = 1'b1;
    for (int b = 0; b < n; b++) begin
      d = seq ? 32'h11 * (b + 1) : $urandom;
      if (b == 0)
        send_beat(id, s, a, c, d, mk(s, a, c, d), $urandom_range(maxd, 0), ok);
      else
        send_beat(id, $urandom, $urandom, 28'($urandom), d, mk(s, a, c, d),
                  $urandom_range(maxd, 0), ok);
      if (!ok) begin
        req[id] = keep;
        return;
      end
    end
    if (!keep) req[id] = 1'b0;
    @(negedge clk);
    chk($sformatf("gnt_held_in_gap_r%0d", id), gnt[id], 1'b1);
    @(negedge clk);
    chk($sformatf("release_r%0d", id), {gnt[id], busy}, 2'b00);
  endtask

  task automatic rand_txn(input int id, input bit last);
    logic [31:0] s;
    logic [27:0] c;
    bit keep;
    s = $urandom;
    if ($urandom_range(1, 0) == 1) s[3:0] = 4'hD;
    else if (s[3:0] == 4'hD) s[3:0] = 4'h3;
    c = (s[3:0] == 4'hD) ? 28'($urandom_range(4, 0)) : 28'($urandom);
    keep = last ? 1'b0 : 1'($urandom_range(1, 0));
    run_txn(id, s, $urandom, c, 4, keep, 1'b0);
    if (!keep) repeat ($urandom_range(3, 0)) @(negedge clk);
  endtask

  initial begin : monitor
    logic  prev_oh;
    logic [1:0] prev_g;
    beat_t e;
    beat_t act;
    prev_oh = 1'b0;
    prev_g  = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_oh = 1'b0;
        prev_g  = 2'b00;
      end else begin
        if (oh_en) begin
          chk("oh_en_single_cycle", prev_oh, 1'b0);
          act = mk(out_status, out_address, out_data_count, out_data);
          if (exp_q.size() == 0) chk("oh_en_unexpected", oh_en, 1'b0);
          else begin
            e = exp_q.pop_front();
            chk("beat", act, e);
          end
        end
        if (timeout_err && !to_expected) chk("timeout_spurious", timeout_err, 1'b0);
        if (gnt == 2'b11) chk("gnt_overlap", gnt[0] & gnt[1], 1'b0);
        for (int i = 0; i < 2; i++) begin
          if (chk_gnt && gnt[i] && !prev_g[i]) begin
            if (exp_gnt_q.size() == 0) chk("gnt_unexpected", gnt[i], 1'b0);
            else chk("gnt_order", i, exp_gnt_q.pop_front());
          end
        end
        prev_oh = oh_en;
        prev_g  = gnt;
      end
    end
  end

  initial begin : ready_noise
    forever begin
      @(negedge clk);
      if (rand_ready) oh_ready = ($urandom_range(3, 0) != 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit ok;
    int n;
    int viol;
    logic [31:0] d0, d1;
    rst = 1'b1; req = 2'b00; en = 2'b00; oh_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      st[i] = '0; ad[i] = '0; dc[i] = '0; da[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 160'd0);
    rst = 1'b0;
    chk_gnt = 1'b1;

    // Single non-burst response.
    exp_gnt_q.push_back(0);
    run_txn(0, 32'h0000_00EE, 32'h0000_1000, 28'd0, 2, 1'b0, 1'b0);
    chk("hold_after_release", out_status, 32'h0000_00EE);

    // Burst of 4 words from r0 while r1 waits.
    exp_gnt_q.push_back(0);
    exp_gnt_q.push_back(1);
    fork
      run_txn(0, 32'h0000_000D, 32'h0000_2000, 28'd3, 1, 1'b0, 1'b1);
      begin
        wait_gnt(0);
        run_txn(1, 32'h0000_0055, 32'h0000_3000, 28'd9, 1, 1'b0, 1'b0);
      end
    join

    // Round-robin from reset with both requesters held high.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_gnt_q = '{0, 1, 0, 1};
    fork
      begin
        run_txn(0, 32'h0000_0001, 32'h0000_0A00, 28'd0, 2, 1'b1, 1'b0);
        run_txn(0, 32'h0000_001D, 32'h0000_0A10, 28'd2, 2, 1'b0, 1'b0);
      end
      begin
        run_txn(1, 32'h0000_002D, 32'h0000_0B00, 28'd1, 2, 1'b1, 1'b0);
        run_txn(1, 32'h0000_0002, 32'h0000_0B10, 28'd5, 2, 1'b0, 1'b0);
      end
    join
    chk("rr_all_grants_seen", exp_gnt_q.size(), 0);

    // Host backpressure between the two beats of a burst.
    exp_gnt_q.push_back(0);
    fork
      run_txn(0, 32'h0000_001D, 32'h0000_4000, 28'd1, 0, 1'b0, 1'b0);
      begin
        wait_oh();
        oh_ready = 1'b0;
        viol = 0;
        repeat (50) begin
          @(negedge clk);
          if (r0_ready || oh_en || !r0_gnt) viol++;
        end
        chk("backpressure_stall", viol, 0);
        oh_ready = 1'b1;
      end
    join

    // r1 stalls after its first beat; r0 is waiting.
    exp_gnt_q.push_back(1);
    exp_gnt_q.push_back(0);
    req[1] = 1'b1;
    wait_gnt(1);
    fork
      begin
        d0 = $urandom;
        send_beat(1, 32'h0000_003D, 32'h0000_5000, 28'd5, d0,
                  mk(32'h0000_003D, 32'h0000_5000, 28'd5, d0), 0, ok);
        wait_rdy(1, ok);
        to_expected = 1'b1;
        n = 0;
        while (!timeout_err && n < 40) begin
          @(negedge clk);
          n++;
        end
        chk("timeout_latency", n, 16);
        chk("timeout_release", {r1_gnt, busy}, 2'b00);
        req[1] = 1'b0;
        @(negedge clk);
        chk("timeout_one_cycle", timeout_err, 1'b0);
        to_expected = 1'b0;
        chk("gnt_after_timeout", gnt, 2'b01);
      end
      run_txn(0, 32'h0000_0077, 32'h0000_6000, 28'd0, 1, 1'b0, 1'b0);
    join

    // Asynchronous reset between beats 2 and 3 of an 8-word burst.
    exp_gnt_q.push_back(0);
    req[0] = 1'b1;
    d0 = $urandom;
    d1 = $urandom;
    send_beat(0, 32'h0000_002D, 32'h0000_7000, 28'd7, d0,
              mk(32'h0000_002D, 32'h0000_7000, 28'd7, d0), 0, ok);
    send_beat(0, 32'hDEAD_BEEF, 32'h1234_5678, 28'd99, d1,
              mk(32'h0000_002D, 32'h0000_7000, 28'd7, d1), 0, ok);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", outs(), 160'd0);
    req[1] = 1'b1;
    exp_gnt_q.push_back(0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_prefers_r0", gnt, 2'b01);
    req = 2'b00;
    repeat (2) @(negedge clk);
    chk("req_drop_release", {gnt, busy, timeout_err}, 4'b0000);
    chk("directed_grants_seen", exp_gnt_q.size(), 0);

    // Randomized traffic from both requesters with host backpressure.
    chk_gnt = 1'b0;
    rand_ready = 1'b1;
    fork
      for (int k = 0; k < 15; k++) rand_txn(0, k == 14);
      for (int k = 0; k < 15; k++) rand_txn(1, k == 14);
    join
    rand_ready = 1'b0;
    oh_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("final_idle", {gnt, busy}, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
